// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave.
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE,
    ACTIVE
  } spi_state_e;

  // Which sck transitions (rising or falling) sample mosi and shift miso.
  typedef struct packed {
    logic sample_rise;
    logic shift_rise;
  } spi_edge_pol_t;

  // Modes 0 and 3 sample on the rising edge; modes 1 and 2 on the falling edge.
  function automatic spi_edge_pol_t edge_pol(input logic cpol, input logic cpha);
    spi_edge_pol_t pol;
    pol.sample_rise = ~(cpol ^ cpha);
    pol.shift_rise  = cpol ^ cpha;
    return pol;
  endfunction

  // Every bit of a word sent when the TX holding register is empty.
  localparam logic UNDERRUN_FILL_BIT = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises the SPI pins into clk and detects sck and ss transitions.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          CPOL        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ss,
  input  logic sck,
  input  logic mosi,
  output logic ss_sync,
  output logic mosi_sync,
  output logic lead_edge,
  output logic trail_edge,
  output logic ss_fall,
  output logic ss_rise
);

  logic [SYNC_STAGES-1:0] ss_q;
  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   ss_h_q;
  logic                   sck_h_q;
  logic                   sck_sync;

  // Synchroniser chains plus one history flop each for ss and sck; reset to idle pin levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q    <= '1;
      sck_q   <= {SYNC_STAGES{CPOL}};
      mosi_q  <= '0;
      ss_h_q  <= 1'b1;
      sck_h_q <= CPOL;
    end else begin
      ss_q    <= {ss_q[SYNC_STAGES-2:0], ss};
      sck_q   <= {sck_q[SYNC_STAGES-2:0], sck};
      mosi_q  <= {mosi_q[SYNC_STAGES-2:0], mosi};
      ss_h_q  <= ss_sync;
      sck_h_q <= sck_sync;
    end
  end

  // Edge pulses relative to the idle level of sck.
  always_comb begin
    ss_sync    = ss_q[SYNC_STAGES-1];
    sck_sync   = sck_q[SYNC_STAGES-1];
    mosi_sync  = mosi_q[SYNC_STAGES-1];
    lead_edge  = (sck_sync != CPOL) && (sck_h_q == CPOL);
    trail_edge = (sck_sync == CPOL) && (sck_h_q != CPOL);
    ss_fall    = ss_h_q & ~ss_sync;
    ss_rise    = ~ss_h_q & ss_sync;
  end

endmodule

// File: rtl/spi_slave_mode.sv
// SPI slave for all four CPOL/CPHA modes with TX holding register and RX valid/ready output.
module spi_slave_mode
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned BIT_CNT_WIDTH = 4,
  parameter bit          CPOL          = 1'b0,
  parameter bit          CPHA          = 1'b0,
  parameter bit          MSB_FIRST     = 1'b1,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  underrun
);

  if (BIT_CNT_WIDTH != $clog2(DATA_WIDTH)) begin : g_bad_cnt_width
    $error("BIT_CNT_WIDTH must equal $clog2(DATA_WIDTH)");
  end
  if (DATA_WIDTH < 2) begin : g_bad_data_width
    $error("DATA_WIDTH must be at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be at least 2");
  end

  localparam spi_edge_pol_t             EdgePol  = edge_pol(CPOL, CPHA);
  localparam logic [DATA_WIDTH-1:0]     FillWord = {DATA_WIDTH{UNDERRUN_FILL_BIT}};
  localparam logic [BIT_CNT_WIDTH-1:0]  LastBit  = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

  logic ss_sync, mosi_sync, lead_edge, trail_edge, ss_fall, ss_rise;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .CPOL        (CPOL)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .ss         (ss),
    .sck        (sck),
    .mosi       (mosi),
    .ss_sync    (ss_sync),
    .mosi_sync  (mosi_sync),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .ss_fall    (ss_fall),
    .ss_rise    (ss_rise)
  );

  spi_state_e               state_q;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt_q;
  logic [DATA_WIDTH-1:0]    tx_shift_q;
  logic [DATA_WIDTH-1:0]    tx_hold_q;
  logic [DATA_WIDTH-1:0]    rx_shift_q;
  // Set when a CPHA=0 word was loaded mid-burst: its first bit is already on miso, so the
  // trailing edge of the previous word's last bit must not advance the shifter.
  logic                     skip_q;

  logic                  sck_rise, sck_fall, sample_edge, shift_edge;
  logic                  do_sample, do_shift, last_bit, frame_start, mid_load, load_word, tx_hs;
  logic [DATA_WIDTH-1:0] load_val, load_rest, tx_rest, rx_next;
  logic                  load_first, tx_first;

  // Edge selection and next-word datapath.
  always_comb begin
    sck_rise    = CPOL ? trail_edge : lead_edge;
    sck_fall    = CPOL ? lead_edge : trail_edge;
    sample_edge = EdgePol.sample_rise ? sck_rise : sck_fall;
    shift_edge  = EdgePol.shift_rise ? sck_rise : sck_fall;

    do_sample   = (state_q == ACTIVE) && !ss_sync && sample_edge;
    do_shift    = (state_q == ACTIVE) && !ss_sync && shift_edge;
    last_bit    = (bit_cnt_q == LastBit);
    frame_start = (state_q == IDLE) && ss_fall;
    mid_load    = do_sample && last_bit;
    load_word   = frame_start || mid_load;
    tx_hs       = tx_valid && tx_ready;

    // tx_ready high means the holding register is empty.
    load_val    = tx_ready ? FillWord : tx_hold_q;
    load_first  = MSB_FIRST ? load_val[DATA_WIDTH-1] : load_val[0];
    load_rest   = MSB_FIRST ? {load_val[DATA_WIDTH-2:0], 1'b1} : {1'b1, load_val[DATA_WIDTH-1:1]};
    tx_first    = MSB_FIRST ? tx_shift_q[DATA_WIDTH-1] : tx_shift_q[0];
    tx_rest     = MSB_FIRST ? {tx_shift_q[DATA_WIDTH-2:0], 1'b1}
                            : {1'b1, tx_shift_q[DATA_WIDTH-1:1]};
    rx_next     = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], mosi_sync}
                            : {mosi_sync, rx_shift_q[DATA_WIDTH-1:1]};
  end

  // Frame FSM, shifters, handshakes and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      rx_shift_q <= '0;
      skip_q     <= 1'b0;
      miso       <= 1'b1;
      miso_oe    <= 1'b0;
      tx_ready   <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      underrun <= 1'b0;

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (load_word) begin
        underrun <= tx_ready;
        tx_ready <= 1'b1;
        if (!CPHA) begin
          miso       <= load_first;
          tx_shift_q <= load_rest;
          skip_q     <= mid_load;
        end else begin
          tx_shift_q <= load_val;
        end
      end

      // Placed after the load so a same-cycle handshake leaves the register full.
      if (tx_hs) begin
        tx_hold_q <= tx_data;
        tx_ready  <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q    <= ACTIVE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            busy       <= 1'b1;
            miso_oe    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            skip_q    <= 1'b0;
            miso      <= 1'b1;
            miso_oe   <= 1'b0;
            busy      <= 1'b0;
          end else begin
            if (do_shift) begin
              if (skip_q) begin
                skip_q <= 1'b0;
              end else begin
                miso       <= tx_first;
                tx_shift_q <= tx_rest;
              end
            end
            if (do_sample) begin
              rx_shift_q <= rx_next;
              bit_cnt_q  <= last_bit ? '0 : bit_cnt_q + BIT_CNT_WIDTH'(1);
              if (last_bit) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                overrun  <= rx_valid && !rx_ready;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_mode.sv
// Directed bench: a mode-0 MSB-first slave (a) and a mode-3 LSB-first slave (b).
module tb_spi_slave_mode;

  localparam int HALF = 80;  // half sck period, 8 clk cycles

  logic clk = 1'b0;
  logic rst;

  logic ss_a, sck_a, mosi_a, miso_a, oe_a, txv_a, txr_a, rxv_a, rxr_a, busy_a, ovr_a, und_a;
  logic ss_b, sck_b, mosi_b, miso_b, oe_b, txv_b, txr_b, rxv_b, rxr_b, busy_b, ovr_b, und_b;
  logic [15:0] txd_a, rxd_a, txd_b, rxd_b;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ovr_a = 0;
  int n_und_a = 0;
  int o0, u0;
  logic [15:0] got;

  spi_slave_mode u_dut_a (
    .clk (clk), .rst (rst), .ss (ss_a), .sck (sck_a), .mosi (mosi_a), .miso (miso_a),
    .miso_oe (oe_a), .tx_data (txd_a), .tx_valid (txv_a), .tx_ready (txr_a),
    .rx_data (rxd_a), .rx_valid (rxv_a), .rx_ready (rxr_a), .busy (busy_a),
    .overrun (ovr_a), .underrun (und_a)
  );

  spi_slave_mode #(.CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_dut_b (
    .clk (clk), .rst (rst), .ss (ss_b), .sck (sck_b), .mosi (mosi_b), .miso (miso_b),
    .miso_oe (oe_b), .tx_data (txd_b), .tx_valid (txv_b), .tx_ready (txr_b),
    .rx_data (rxd_b), .rx_valid (rxv_b), .rx_ready (rxr_b), .busy (busy_b),
    .overrun (ovr_b), .underrun (und_b)
  );

  always #5 clk = ~clk;

  // Pulse counters for slave a.
  always @(posedge clk) begin
    if (ovr_a) n_ovr_a <= n_ovr_a + 1;
    if (und_a) n_und_a <= n_und_a + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ss(input int w, input logic v);
    if (w == 0) ss_a = v; else ss_b = v;
  endtask
  task automatic set_sck(input int w, input logic v);
    if (w == 0) sck_a = v; else sck_b = v;
  endtask
  task automatic set_mosi(input int w, input logic v);
    if (w == 0) mosi_a = v; else mosi_b = v;
  endtask
  task automatic set_rdy(input int w, input logic v);
    if (w == 0) rxr_a = v; else rxr_b = v;
  endtask
  function automatic logic get_miso(input int w);
    return (w == 0) ? miso_a : miso_b;
  endfunction

  task automatic push(input int w, input logic [15:0] d);
    if (w == 0) begin txd_a = d; txv_a = 1'b1; end
    else begin txd_b = d; txv_b = 1'b1; end
    #10;
    txv_a = 1'b0;
    txv_b = 1'b0;
  endtask

  task automatic select(input int w);
    set_ss(w, 1'b0);
    #HALF;
  endtask

  task automatic deselect(input int w);
    set_ss(w, 1'b1);
    #HALF;
  endtask

  // Master side of one word. Slave a: mode 0 MSB first; slave b: mode 3 LSB first.
  // With rdy_at_end, rx_ready is high only on the clk edge that completes the word.
  task automatic xfer(input int w, input logic [15:0] word, input int nbits,
                      input bit rdy_at_end, output logic [15:0] rd);
    int  idx;
    bit  last;
    rd = 16'h0;
    for (int i = 0; i < nbits; i++) begin
      idx  = (w == 0) ? 15 - i : i;
      last = (i == nbits - 1);
      if (w == 0) begin
        set_mosi(w, word[idx]);
        #HALF;
        rd[idx] = get_miso(w);
        set_sck(w, 1'b1);
      end else begin
        set_sck(w, 1'b0);
        set_mosi(w, word[idx]);
        #HALF;
        rd[idx] = get_miso(w);
        set_sck(w, 1'b1);
      end
      if (last && rdy_at_end) begin
        #20;
        set_rdy(w, 1'b1);
        #10;
        set_rdy(w, 1'b0);
        #(HALF - 30);
      end else begin
        #HALF;
      end
      if (w == 0) set_sck(w, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    ss_a = 1'b1; sck_a = 1'b0; mosi_a = 1'b0; txd_a = '0; txv_a = 1'b0; rxr_a = 1'b0;
    ss_b = 1'b1; sck_b = 1'b1; mosi_b = 1'b0; txd_b = '0; txv_b = 1'b0; rxr_b = 1'b0;
    #20;
    check("rst_miso", miso_a, 1);
    check("rst_oe", oe_a, 0);
    check("rst_tx_ready", txr_a, 1);
    check("rst_rx_data", rxd_a, 0);
    check("rst_rx_valid", rxv_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_overrun", ovr_a, 0);
    check("rst_underrun", und_a, 0);
    check("rst_b_miso", miso_b, 1);
    check("rst_b_tx_ready", txr_b, 1);
    #10;
    rst = 1'b0;
    #20;

    // Mode 0, MSB first
    push(0, 16'hA5C3);
    check("m0_tx_ready_full", txr_a, 0);
    o0 = n_ovr_a; u0 = n_und_a;
    select(0);
    check("m0_busy", busy_a, 1);
    check("m0_oe", oe_a, 1);
    check("m0_tx_ready_loaded", txr_a, 1);
    xfer(0, 16'h1234, 16, 1'b0, got);
    check("m0_miso_word", got, 16'hA5C3);
    check("m0_rx_valid", rxv_a, 1);
    check("m0_rx_data", rxd_a, 16'h1234);
    deselect(0);
    check("m0_oe_off", oe_a, 0);
    check("m0_busy_off", busy_a, 0);
    check("m0_miso_idle", miso_a, 1);
    // The load at the last bit finds the holding register empty.
    check("m0_underruns", n_und_a - u0, 1);
    check("m0_overruns", n_ovr_a - o0, 0);
    set_rdy(0, 1'b1);
    #10;
    set_rdy(0, 1'b0);
    check("m0_rx_accepted", rxv_a, 0);

    // Mode 3, LSB first
    push(1, 16'h00FF);
    select(1);
    xfer(1, 16'h8001, 16, 1'b0, got);
    deselect(1);
    check("m3_miso_word", got, 16'h00FF);
    check("m3_rx_data", rxd_b, 16'h8001);
    check("m3_rx_valid", rxv_b, 1);

    // Three-word burst, two words queued, rx_ready held low
    o0 = n_ovr_a; u0 = n_und_a;
    push(0, 16'h1111);
    select(0);
    push(0, 16'h2222);
    check("burst_tx_ready", txr_a, 0);
    xfer(0, 16'hAAAA, 16, 1'b0, got);
    check("burst_w1", got, 16'h1111);
    check("burst_w1_und", n_und_a - u0, 0);
    xfer(0, 16'h5555, 16, 1'b0, got);
    check("burst_w2", got, 16'h2222);
    check("burst_w2_und", n_und_a - u0, 1);
    check("burst_w2_ovr", n_ovr_a - o0, 1);
    xfer(0, 16'h0F0F, 16, 1'b0, got);
    check("burst_w3", got, 16'hFFFF);
    deselect(0);
    check("burst_ovr", n_ovr_a - o0, 2);
    check("burst_und", n_und_a - u0, 2);
    check("burst_rx_data", rxd_a, 16'h0F0F);
    check("burst_rx_valid", rxv_a, 1);

    // Frame aborted after 7 bits
    set_rdy(0, 1'b1);
    #10;
    set_rdy(0, 1'b0);
    push(0, 16'hC3C3);
    o0 = n_ovr_a; u0 = n_und_a;
    select(0);
    xfer(0, 16'hFFFF, 7, 1'b0, got);
    deselect(0);
    check("abort_rx_valid", rxv_a, 0);
    check("abort_miso", miso_a, 1);
    check("abort_oe", oe_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_ovr", n_ovr_a - o0, 0);
    check("abort_und", n_und_a - u0, 0);
    push(0, 16'h3C5A);
    select(0);
    xfer(0, 16'hBEEF, 16, 1'b0, got);
    deselect(0);
    check("after_abort_miso", got, 16'h3C5A);
    check("after_abort_rx_data", rxd_a, 16'hBEEF);
    check("after_abort_rx_valid", rxv_a, 1);

    // rx_ready coincides with word completion while rx_valid is already set
    o0 = n_ovr_a;
    select(0);
    xfer(0, 16'h6D2B, 16, 1'b1, got);
    deselect(0);
    check("same_cycle_rx_valid", rxv_a, 1);
    check("same_cycle_rx_data", rxd_a, 16'h6D2B);
    check("same_cycle_ovr", n_ovr_a - o0, 0);

    // Asynchronous reset in the middle of a word
    push(0, 16'h0000);
    select(0);
    push(0, 16'h7E7E);
    xfer(0, 16'hFFFF, 5, 1'b0, got);
    check("pre_rst_miso", miso_a, 0);
    #3;
    rst = 1'b1;
    #1;
    check("arst_miso", miso_a, 1);
    check("arst_oe", oe_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_tx_ready", txr_a, 1);
    check("arst_rx_valid", rxv_a, 0);
    check("arst_rx_data", rxd_a, 0);
    check("arst_overrun", ovr_a, 0);
    check("arst_underrun", und_a, 0);
    #6;
    ss_a = 1'b1;
    sck_a = 1'b0;
    #20;
    rst = 1'b0;
    #20;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
